// File: rtl/mdio_cmd_sequencer_if.sv
// Request, engine and response signals of the MDIO command sequencer.
// slave = sequencer side, master = requester/engine/consumer side.
interface mdio_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [4:0]    req_phy;
  logic [4:0]    req_reg;
  logic [15:0]   req_wdata;

  logic          new_cmd;
  logic [31:0]   cmd;
  logic          mdio_rdy;
  logic          mdio_written;
  logic          mdio_read;
  logic [15:0]   mdio_rdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [15:0]   rsp_rdata;
  logic          rsp_error;

  logic          busy;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  req_valid, req_write, req_phy, req_reg, req_wdata,
    input  mdio_rdy, mdio_written, mdio_read, mdio_rdata,
    input  rsp_ready,
    output req_ready, new_cmd, cmd,
    output rsp_valid, rsp_write, rsp_rdata, rsp_error,
    output busy, fifo_count
  );

  modport master (
    output req_valid, req_write, req_phy, req_reg, req_wdata,
    output mdio_rdy, mdio_written, mdio_read, mdio_rdata,
    output rsp_ready,
    input  req_ready, new_cmd, cmd,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_error,
    input  busy, fifo_count
  );
endinterface

// File: rtl/mdio_cmd_sequencer.sv
// Queues MDIO register requests, packs Clause-22 frames for the bit
// engine, runs its new_cmd/rdy handshake and returns one response each.
module mdio_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mdio_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic          issue;
  logic          finish;
  logic          timed_out;
  logic          done_err;
  logic [TW-1:0] timer;

  logic          new_cmd;
  logic [31:0]   cmd;
  logic          rsp_write;
  logic [15:0]   rsp_rdata;
  logic          rsp_error;

  // Bit index of the frame word is transmit order.
  function automatic logic [31:0] pack(req_t r);
    logic [31:0] f;
    f    = '0;
    f[1] = 1'b1;
    f[2] = ~r.write;
    f[3] = r.write;
    for (int k = 0; k < 5; k++) begin
      f[4+k] = r.phy[4-k];
      f[9+k] = r.regad[4-k];
    end
    f[14] = r.write;
    for (int k = 0; k < 16; k++) begin
      f[16+k] = r.write & r.wdata[15-k];
    end
    return f;
  endfunction

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = issue;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.req_write, bus.req_phy,
                      bus.req_reg, bus.req_wdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign done_err = ~(rsp_write ? bus.mdio_written : bus.mdio_read);

  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && bus.mdio_rdy) begin
          issue   = 1'b1;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (timer == TW'(TIMEOUT)) begin
          timed_out = 1'b1;
          state_n   = RESP;
        end else if (!bus.mdio_rdy) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timer == TW'(TIMEOUT)) begin
          timed_out = 1'b1;
          state_n   = RESP;
        end else if (bus.mdio_rdy) begin
          finish  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_cmd   <= 1'b0;
      cmd       <= '0;
      timer     <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      new_cmd <= issue;
      if (issue) begin
        cmd       <= pack(head);
        rsp_write <= head.write;
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
        timer     <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        timer <= timer + 1'b1;
      end
      // Timeout wins over a completion seen on the same edge.
      if (timed_out) begin
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end else if (finish) begin
        rsp_error <= done_err;
        rsp_rdata <= (!rsp_write && !done_err) ? bus.mdio_rdata : 16'h0;
      end
    end
  end

  assign bus.req_ready  = (count != CW'(DEPTH));
  assign bus.fifo_count = count;
  assign bus.new_cmd    = new_cmd;
  assign bus.cmd        = cmd;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_write  = rsp_write;
  assign bus.rsp_rdata  = rsp_rdata;
  assign bus.rsp_error  = rsp_error;
  assign bus.busy       = (state != IDLE);
endmodule
